// File: rtl/rand_num_gen.sv
// Two-LFSR pseudo-random direction generator for the maze carver: a 32-bit and a
// 31-bit Fibonacci LFSR whose low bits are XORed into a registered 2-bit code.
// The output is named rand_val because "rand" is a reserved SystemVerilog keyword.
module rand_num_gen #(
  parameter logic [31:0] SEED_A = 32'h0000_0001,
  parameter logic [30:0] SEED_B = 31'h0000_0001
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] rand_val
);

  // An all-zero seed would lock the register up, so it is replaced by 1.
  localparam logic [31:0] INIT_A = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
  localparam logic [30:0] INIT_B = (SEED_B == 31'd0) ? 31'd1 : SEED_B;

  // Declaration initialisers give the reset state before the first reset.
  logic [31:0] a        = INIT_A;
  logic [30:0] b        = INIT_B;
  logic [1:0]  rand_p0  = 2'b00;
  logic [31:0] a_next;
  logic [30:0] b_next;

  function automatic logic [31:0] lfsr_a_step(input logic [31:0] cur);
    logic fa;
    if (cur == 32'd0) begin
      return 32'd1;
    end
    fa = cur[31] ^ cur[21] ^ cur[1] ^ cur[0];
    return {cur[30:0], fa};
  endfunction

  function automatic logic [30:0] lfsr_b_step(input logic [30:0] cur);
    logic fb;
    if (cur == 31'd0) begin
      return 31'd1;
    end
    fb = cur[30] ^ cur[27];
    return {cur[29:0], fb};
  endfunction

  function automatic logic [1:0] mix(input logic [31:0] na, input logic [30:0] nb);
    return na[1:0] ^ nb[1:0];
  endfunction

  always_comb begin
    a_next = lfsr_a_step(a);
    b_next = lfsr_b_step(b);
  end

  // Stage p0: LFSR state and the output code are registered on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a       <= INIT_A;
      b       <= INIT_B;
      rand_p0 <= 2'b00;
    end else begin
      a       <= a_next;
      b       <= b_next;
      rand_p0 <= mix(a_next, b_next);
    end
  end

  assign rand_val = rand_p0;

endmodule

// File: tb/tb_rand_num_gen.sv
// Scoreboard bench for rand_num_gen: three instances (default, custom and zero seeds)
// checked each cycle against a reference model plus fixed expected sequences.
module tb_rand_num_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0 = 1'b1, reset1 = 1'b1, reset2 = 1'b1;
  logic [1:0] rand0, rand1, rand2;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] CS_A = 32'hACE1_2468;
  localparam logic [30:0] CS_B = 31'h1234_5678;

  logic [31:0] ma0 = 32'd1, ma1 = CS_A, ma2 = 32'd1;
  logic [30:0] mb0 = 31'd1, mb1 = CS_B, mb2 = 31'd1;
  logic [1:0]  q0[$], q1[$], q2[$];

  rand_num_gen dut0 (.clk(clk), .reset(reset0), .rand_val(rand0));
  rand_num_gen #(.SEED_A(CS_A), .SEED_B(CS_B)) dut1 (.clk(clk), .reset(reset1), .rand_val(rand1));
  rand_num_gen #(.SEED_A(32'd0), .SEED_B(31'd0)) dut2 (.clk(clk), .reset(reset2), .rand_val(rand2));

  function automatic logic [31:0] ref_a(input logic [31:0] x);
    if (x == 32'd0) return 32'd1;
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [30:0] ref_b(input logic [30:0] x);
    if (x == 31'd0) return 31'd1;
    return {x[29:0], x[30] ^ x[27]};
  endfunction

  // One clock: drive resets, push model predictions, then pop and compare at negedge.
  task automatic tick(input logic r0, input logic r1, input logic r2);
    logic [1:0] e;
    reset0 = r0; reset1 = r1; reset2 = r2;
    if (r0) begin ma0 = 32'd1; mb0 = 31'd1; q0.push_back(2'b00); end
    else begin ma0 = ref_a(ma0); mb0 = ref_b(mb0); q0.push_back(ma0[1:0] ^ mb0[1:0]); end
    if (r1) begin ma1 = CS_A; mb1 = CS_B; q1.push_back(2'b00); end
    else begin ma1 = ref_a(ma1); mb1 = ref_b(mb1); q1.push_back(ma1[1:0] ^ mb1[1:0]); end
    if (r2) begin ma2 = 32'd1; mb2 = 31'd1; q2.push_back(2'b00); end
    else begin ma2 = ref_a(ma2); mb2 = ref_b(mb2); q2.push_back(ma2[1:0] ^ mb2[1:0]); end
    @(posedge clk);
    @(negedge clk);
    e = q0.pop_front(); vectors++;
    if (rand0 !== e) begin
      miscompares++; $display("FAIL model_dut0 t=%0t: got %b, want %b", $time, rand0, e);
    end
    e = q1.pop_front(); vectors++;
    if (rand1 !== e) begin
      miscompares++; $display("FAIL model_dut1 t=%0t: got %b, want %b", $time, rand1, e);
    end
    e = q2.pop_front(); vectors++;
    if (rand2 !== e) begin
      miscompares++; $display("FAIL model_dut2 t=%0t: got %b, want %b", $time, rand2, e);
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    vectors++;
    if (rand0 !== 2'b00) begin miscompares++; $display("FAIL reset_rand0: got %b, want 00", rand0); end
    vectors++;
    if (rand2 !== 2'b00) begin miscompares++; $display("FAIL reset_rand2: got %b, want 00", rand2); end
    vectors++;
    if (dut0.a !== 32'd1 || dut0.b !== 31'd1) begin
      miscompares++; $display("FAIL reset_state0: got a=%h b=%h, want a=1 b=1", dut0.a, dut0.b);
    end
    vectors++;
    if (dut2.a !== 32'd1 || dut2.b !== 31'd1) begin
      miscompares++; $display("FAIL zero_seed_state: got a=%h b=%h, want a=1 b=1", dut2.a, dut2.b);
    end
    vectors++;
    if (dut1.a !== CS_A || dut1.b !== CS_B) begin
      miscompares++; $display("FAIL reset_state1: got a=%h b=%h, want a=%h b=%h", dut1.a, dut1.b, CS_A, CS_B);
    end
  endtask

  task automatic test_first_values();
    logic [1:0] exp_seq [3];
    exp_seq = '{2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      vectors++;
      if (rand0 !== exp_seq[i]) begin
        miscompares++; $display("FAIL first_seq[%0d]: got %b, want %b", i, rand0, exp_seq[i]);
      end
      vectors++;
      if (rand2 !== exp_seq[i]) begin
        miscompares++; $display("FAIL zero_seed_seq[%0d]: got %b, want %b", i, rand2, exp_seq[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] exp_seq [3];
    exp_seq = '{2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    vectors++;
    if (rand0 !== 2'b00) begin miscompares++; $display("FAIL mid_reset: got %b, want 00", rand0); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      vectors++;
      if (rand0 !== exp_seq[i]) begin
        miscompares++; $display("FAIL restart_seq[%0d]: got %b, want %b", i, rand0, exp_seq[i]);
      end
    end
  endtask

  task automatic test_long_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      vectors++;
      if (rand0 !== 2'b00) begin
        miscompares++; $display("FAIL long_reset[%0d]: got %b, want 00", i, rand0);
      end
    end
  endtask

  task automatic test_distribution();
    int cnt [4];
    int run1, max1, run2, max2;
    logic [1:0] last1, last2;
    cnt = '{0, 0, 0, 0};
    run1 = 0; max1 = 0; run2 = 0; max2 = 0;
    last1 = 2'bxx; last2 = 2'bxx;
    for (int i = 0; i < 4096; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      cnt[rand1]++;
      run1 = (rand1 === last1) ? run1 + 1 : 1;
      run2 = (rand2 === last2) ? run2 + 1 : 1;
      if (run1 > max1) max1 = run1;
      if (run2 > max2) max2 = run2;
      last1 = rand1; last2 = rand2;
    end
    for (int v = 0; v < 4; v++) begin
      vectors++;
      if (cnt[v] < 900 || cnt[v] > 1150) begin
        miscompares++; $display("FAIL dist_count[%0d]: got %0d, want 900..1150", v, cnt[v]);
      end
    end
    vectors++;
    if (max1 > 16) begin miscompares++; $display("FAIL max_run_dut1: got %0d, want <=16", max1); end
    vectors++;
    if (max2 > 16) begin miscompares++; $display("FAIL max_run_dut2: got %0d, want <=16", max2); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20000; i++) begin
      if (i == 9000 || i == 9001) tick(1'b1, 1'b1, 1'b1);
      else tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_first_values();
    test_mid_reset();
    test_long_reset();
    test_distribution();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
